// File: rtl/pdu_pkg.sv
// Shared PDU definitions: divider width, reset divisor and divisor type.
package pdu_pkg;
    localparam int          DIV_W       = 20;
    localparam int unsigned DIV_RST_DEF = 200000;

    typedef logic [DIV_W-1:0] div_t;
endpackage

// File: rtl/freq_div_chan.sv
// One divider channel: counter, active/pending divisor, registered tick/sq/busy.
module freq_div_chan #(
    parameter int          W       = 20,
    parameter int unsigned DIV_RST = 200000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_sync,
    input  logic         i_wr,
    input  logic [W-1:0] i_val,
    output logic         o_tick,
    output logic         o_sq,
    output logic         o_busy
);
    localparam logic [W-1:0] RST_DIV = W'(DIV_RST);

    logic [W-1:0] r_cnt, r_div_act, r_div_pend;
    logic         r_pend, r_tick, r_sq;

    logic [W-1:0] w_val, w_cnt_n, w_act_n, w_pendv_n;
    logic         w_pend_n, w_tick_n, w_sq_n, w_term;

    always_comb begin
        w_val     = (i_val == '0) ? W'(1) : i_val;
        w_term    = (r_cnt == r_div_act - W'(1));
        w_cnt_n   = r_cnt;
        w_act_n   = r_div_act;
        w_pendv_n = r_div_pend;
        w_pend_n  = r_pend;
        w_tick_n  = 1'b0;
        w_sq_n    = 1'b0;
        if (!i_en) begin
            // Idle channel: counter is parked at 0, so divisors can change at once.
            w_cnt_n  = '0;
            w_act_n  = r_div_pend;
            w_pend_n = 1'b0;
            if (i_wr) begin
                w_pendv_n = w_val;
                w_act_n   = w_val;
            end
        end else begin
            if (i_sync || w_term) begin
                w_cnt_n  = '0;
                w_tick_n = !i_sync;
                if (r_pend) begin
                    w_act_n  = r_div_pend;
                    w_pend_n = 1'b0;
                end
            end else begin
                w_cnt_n = r_cnt + W'(1);
            end
            // A write landing on the applying edge stays pending for the next period.
            if (i_wr) begin
                w_pendv_n = w_val;
                w_pend_n  = 1'b1;
            end
            w_sq_n = (w_cnt_n < (w_act_n >> 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div_act  <= RST_DIV;
            r_div_pend <= RST_DIV;
            r_pend     <= 1'b0;
            r_tick     <= 1'b0;
            r_sq       <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_n;
            r_div_act  <= w_act_n;
            r_div_pend <= w_pendv_n;
            r_pend     <= w_pend_n;
            r_tick     <= w_tick_n;
            r_sq       <= w_sq_n;
        end
    end

    assign o_tick = r_tick;
    assign o_sq   = r_sq;
    assign o_busy = r_pend;
endmodule

// File: rtl/freq_div_multi.sv
// Multi-channel clock-enable generator: divisor write decode and sync fan-out.
module freq_div_multi
    import pdu_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          W       = DIV_W,
    parameter int unsigned DIV_RST = DIV_RST_DEF,
    localparam int         CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           div_wr,
    input  logic [CW-1:0]  div_ch,
    input  logic [W-1:0]   div_val,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic [NCH-1:0] busy
);
    logic [NCH-1:0] w_wr;

    // Out-of-range channel numbers match no lane and are dropped.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < NCH; i++)
            if (div_wr && (32'(div_ch) == i))
                w_wr[i] = 1'b1;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        freq_div_chan #(
            .W       (W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_en   (en[g]),
            .i_sync (sync),
            .i_wr   (w_wr[g]),
            .i_val  (div_val),
            .o_tick (tick[g]),
            .o_sq   (sq[g]),
            .o_busy (busy[g])
        );
    end
endmodule

// File: tb/tb_freq_div_multi.sv
// Scoreboard bench for freq_div_multi: expected ticks and sq/busy snapshots keyed by edge.
module tb_freq_div_multi;
    typedef struct {
        int         at;
        logic [3:0] v;
    } tick_t;

    typedef struct {
        int         at;
        int         kind;   // 0 = sq, 1 = busy
        logic [3:0] m;
        logic [3:0] v;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  en = '0;
    logic        sync = 1'b0;
    logic        div_wr = 1'b0;
    logic [1:0]  div_ch = '0;
    logic [19:0] div_val = '0;
    logic [3:0]  tick, sq, busy;

    int    e = -1;
    int    n_cmp = 0;
    int    n_fail = 0;
    bit    done = 1'b0;
    tick_t tq[$];
    snap_t snq[$];

    freq_div_multi #(.NCH(4), .W(20), .DIV_RST(5)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .div_wr(div_wr),
        .div_ch(div_ch), .div_val(div_val), .tick(tick), .sq(sq), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void xt(input int at, input logic [3:0] v);
        tick_t t;
        t.at = at; t.v = v;
        tq.push_back(t);
    endfunction

    function automatic void xs(input int kind, input int at, input logic [3:0] m, input logic [3:0] v);
        snap_t s;
        s.at = at; s.kind = kind; s.m = m; s.v = v;
        snq.push_back(s);
    endfunction

    task automatic go(input int k);
        while (e < k - 1) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [19:0] v);
        div_wr = 1'b1; div_ch = ch; div_val = v;
    endtask

    // Monitor: edge counter, tick scoreboard, snapshot checks, summary.
    initial begin
        tick_t      t;
        snap_t      keep[$];
        logic [3:0] act;
        forever begin
            @(posedge clk); #1;
            e++;
            while (tq.size() > 0 && tq[0].at < e) begin
                t = tq.pop_front();
                n_cmp++; n_fail++;
                $display("FAIL tick_missed: edge %0d required tick=%b, tick stayed low", t.at, t.v);
            end
            if (tick != 4'b0) begin
                n_cmp++;
                if (tq.size() == 0) begin
                    n_fail++;
                    $display("FAIL tick_unexpected: edge %0d tick=%b, required none", e, tick);
                end else begin
                    t = tq.pop_front();
                    if (t.at != e || t.v != tick) begin
                        n_fail++;
                        $display("FAIL tick: edge %0d tick=%b, required edge %0d tick=%b", e, tick, t.at, t.v);
                    end
                end
            end
            keep = {};
            foreach (snq[i]) begin
                if (snq[i].at <= e) begin
                    n_cmp++;
                    act = (snq[i].kind == 0) ? sq : busy;
                    if (snq[i].at != e || (act & snq[i].m) != snq[i].v) begin
                        n_fail++;
                        $display("FAIL %s: edge %0d got %b (mask %b), required %b at edge %0d",
                                 (snq[i].kind == 0) ? "sq" : "busy", e, act & snq[i].m,
                                 snq[i].m, snq[i].v, snq[i].at);
                    end
                end else begin
                    keep.push_back(snq[i]);
                end
            end
            snq = keep;
            if (done) begin
                n_cmp++;
                if (tq.size() != 0) begin
                    n_fail++;
                    $display("FAIL tick_left: %0d expected ticks never observed, required 0", tq.size());
                end
                n_cmp++;
                if (snq.size() != 0) begin
                    n_fail++;
                    $display("FAIL snap_left: %0d snapshots unchecked, required 0", snq.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: edge %0d reached time limit, required completion", e);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [9:0] pat;
        // Reset, then ch0/ch1 at div 5; ch1 rewritten to 3 mid-period.
        go(0);
        rst = 1'b1;
        xt(8, 4'b0011); xt(11, 4'b0010); xt(13, 4'b0001);
        xt(14, 4'b0010); xt(17, 4'b0010); xt(18, 4'b0001);
        xs(0, 2, 4'hF, 4'h0); xs(1, 2, 4'hF, 4'h0);
        pat = 10'b1000110001;   // bit k = sq[0] after edge 4+k
        for (int k = 0; k < 10; k++) xs(0, 4 + k, 4'b0001, {3'b0, pat[k]});
        xs(1, 5, 4'b0010, 4'b0000); xs(1, 6, 4'b0010, 4'b0010);
        xs(1, 7, 4'b0010, 4'b0010); xs(1, 8, 4'b0010, 4'b0000);
        xs(0, 19, 4'b0011, 4'b0000);
        go(4);  rst = 1'b0; en = 4'b0011;
        go(6);  wr(2'd1, 20'd3);
        go(7);  div_wr = 1'b0;
        go(19); en = 4'b0000;

        // Disabled ch2 written with 0 (-> 1), then with 1.
        go(22);
        for (int k = 23; k <= 26; k++) xt(k, 4'b0100);
        for (int k = 29; k <= 31; k++) xt(k, 4'b0100);
        xs(0, 23, 4'b0100, 4'b0000); xs(0, 26, 4'b0100, 4'b0000); xs(0, 30, 4'b0100, 4'b0000);
        wr(2'd2, 20'd0);
        go(23); div_wr = 1'b0; en = 4'b0100;
        go(27); en = 4'b0000;
        go(28); wr(2'd2, 20'd1);
        go(29); div_wr = 1'b0; en = 4'b0100;
        go(32); en = 4'b0000;

        // ch0/ch3 at div 4 staggered; sync aligns; sync on terminal; pending write.
        go(33);
        xt(38, 4'b0001); xt(40, 4'b1000); xt(42, 4'b0001); xt(44, 4'b1000);
        xt(46, 4'b0001); xt(48, 4'b1000); xt(50, 4'b0001); xt(52, 4'b1000);
        xt(54, 4'b0001); xt(59, 4'b1001); xt(63, 4'b1001); xt(71, 4'b1001);
        xt(73, 4'b0001); xt(75, 4'b1001);
        xs(0, 55, 4'b0001, 4'b0001); xs(0, 57, 4'b0001, 4'b0000);
        xs(1, 68, 4'b0001, 4'b0000); xs(1, 69, 4'b0001, 4'b0001);
        xs(1, 70, 4'b0001, 4'b0001); xs(1, 71, 4'b0001, 4'b0000);
        xs(0, 76, 4'b1001, 4'b0000);
        wr(2'd0, 20'd4);
        go(34); wr(2'd3, 20'd4);
        go(35); div_wr = 1'b0; en = 4'b0001;
        go(37); en = 4'b1001;
        go(55); sync = 1'b1;
        go(56); sync = 1'b0;
        go(67); sync = 1'b1;
        go(68); sync = 1'b0;
        go(69); wr(2'd0, 20'd2);
        go(70); div_wr = 1'b0;
        go(76); en = 4'b0000;

        // Reset mid-period with a pending write plus simultaneous sync/write.
        go(80);
        xt(82, 4'b0010); xt(89, 4'b0010);
        xs(1, 83, 4'b0010, 4'b0010);
        xs(1, 84, 4'hF, 4'h0); xs(0, 84, 4'hF, 4'h0);
        xs(1, 89, 4'b0010, 4'b0000);
        en = 4'b0010;
        go(83); wr(2'd1, 20'd7);
        go(84); rst = 1'b1; sync = 1'b1; wr(2'd1, 20'd9);
        go(85); rst = 1'b0; sync = 1'b0; div_wr = 1'b0;
        go(90); en = 4'b0000;
        go(93); done = 1'b1;
    end
endmodule
